demux_1x4_stream: RTL and testbench

//   Registered 1-to-4 stream demultiplexer, the distribution counterpart of the
//   4:1 selector. Routes each word from one valid/ready input to one of four

---
 rtl/demux_1x4_stream.sv | 69 ++++++
 tb/tb_demux_1x4_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Each output channel owns a one-entry holding register.
module demux_1x4_stream #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [DW-1:0]   out_data0,
    output logic [DW-1:0]   out_data1,
    output logic [DW-1:0]   out_data2,
    output logic [DW-1:0]   out_data3,
    output logic [CNTW-1:0] xfer_cnt
);

    logic [3:0]      valid_q, valid_d;
    logic [DW-1:0]   data_q [4];
    logic [DW-1:0]   data_d [4];
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            accept;

    // A full channel can still take a word in the cycle it drains.
    assign in_ready = ~rst & (~valid_q[sel] | out_ready[sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q + CNTW'(accept);
        for (int k = 0; k < 4; k++) begin
            if (accept && sel == 2'(k)) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed and scoreboard-driven bench for demux_1x4_stream.
// Inputs change 1 time unit after the rising edge.
module tb_demux_1x4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0] xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1x4_stream #(.DW(8), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] od(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] mfull;
    logic [7:0] seq [4];
    logic [7:0] nxt [4];
    logic [7:0] ecnt;
    logic       eready;
    logic       acc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        sel       = 2'd0;
        out_ready = 4'b0000;

        // reset state, word offered during reset is refused
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_cnt", 32'(xfer_cnt), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_data0", 32'(out_data0), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // single route
        tick();
        in_valid  = 1'b1;
        sel       = 2'd2;
        in_data   = 8'hA5;
        out_ready = 4'b1111;
        #1;
        chk("t2_ready", 32'(in_ready), 32'h1);
        tick();
        chk("t2_valid", 32'(out_valid), 32'h4);
        chk("t2_data2", 32'(out_data2), 32'hA5);
        chk("t2_cnt", 32'(xfer_cnt), 32'h1);
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // reset mid-stream with ch2 full
        tick();
        chk("t1_full", 32'(out_valid), 32'h4);
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", 32'(out_valid), 32'h0);
        chk("t1_cnt", 32'(xfer_cnt), 32'h0);
        chk("t1_ready", 32'(in_ready), 32'h0);
        chk("t1_data2", 32'(out_data2), 32'h0);
        tick();
        chk("t1_noacc", 32'(out_valid), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // stall isolation
        tick();
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 8'h11;
        tick();
        chk("t3_v1", 32'(out_valid), 32'h2);
        in_data = 8'h22;
        #1;
        chk("t3_refuse", 32'(in_ready), 32'h0);
        tick();
        chk("t3_hold", 32'(out_data1), 32'h11);
        chk("t3_cnt1", 32'(xfer_cnt), 32'h1);
        sel     = 2'd3;
        in_data = 8'h33;
        #1;
        chk("t3_ready3", 32'(in_ready), 32'h1);
        tick();
        chk("t3_data3", 32'(out_data3), 32'h33);
        chk("t3_valid", 32'(out_valid), 32'hA);
        chk("t3_cnt2", 32'(xfer_cnt), 32'h2);

        // back-to-back on ch0, no bubble
        out_ready = 4'b1111;
        sel       = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'(i);
            #1;
            chk("t4_ready", 32'(in_ready), 32'h1);
            tick();
            chk("t4_data0", 32'(out_data0), 32'(i));
            chk("t4_valid", 32'(out_valid), 32'h1);
            chk("t4_cnt", 32'(xfer_cnt), 32'(2 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("t4_drained", 32'(out_valid), 32'h0);
        chk("t4_keep", 32'(out_data0), 32'h03);

        // counter wrap
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 254) chk("t5_cnt255", 32'(xfer_cnt), 32'd255);
        end
        chk("t5_wrap", 32'(xfer_cnt), 32'h0);
        chk("t5_last", 32'(out_data0), 32'hFF);

        // random soak against a per-channel scoreboard
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst   = 1'b0;
        mfull = 4'b0000;
        ecnt  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            seq[k] = 8'h00;
            nxt[k] = 8'h00;
        end
        for (int n = 0; n < 600; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom);
            in_data   = seq[sel];
            #1;
            eready = ~mfull[sel] | out_ready[sel];
            chk("soak_ready", 32'(in_ready), 32'(eready));
            acc = in_valid & eready;
            for (int k = 0; k < 4; k++) begin
                if (mfull[k] && out_ready[k]) begin
                    chk("soak_order", 32'(od(k)), 32'(nxt[k]));
                    nxt[k]   = nxt[k] + 8'h01;
                    mfull[k] = 1'b0;
                end
            end
            if (acc) begin
                mfull[sel] = 1'b1;
                seq[sel]   = seq[sel] + 8'h01;
                ecnt       = ecnt + 8'h01;
            end
            tick();
            chk("soak_valid", 32'(out_valid), 32'(mfull));
            chk("soak_cnt", 32'(xfer_cnt), 32'(ecnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
